glb_stream_arbiter: RTL

- Shares one 17-bit ready/valid GLB read channel between NUM_PORTS requesters.
- Each requester sends length-prefixed blocks: one header word carrying the size in [15:0], then exactly that many data words.
- Grants a whole block (header plus body) to one requester at a time, round-robin, and never interleaves words of different blocks.
- Sits between the tile-side stream sources and the single GLB read sink.

---
 rtl/glb_stream_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/glb_stream_arbiter.sv
// Block-granular round-robin arbiter sharing one ready/valid GLB read channel.
// Each grant covers one length-prefixed block (header word plus its body words).
module glb_stream_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 17,
    parameter int ID_WIDTH   = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            busy,
    output logic                            block_done,
    output logic [15:0]                     blocks_total
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_WIDTH-1:0]     r_grant_id;
    logic [ID_WIDTH-1:0]     w_grant_nxt;
    logic [ID_WIDTH-1:0]     w_pick;
    logic                    w_any;
    logic [15:0]             r_remaining;
    logic [15:0]             w_remaining_nxt;
    logic                    r_block_done;
    logic                    w_done;
    logic [15:0]             r_blocks_total;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_sel_valid;
    logic [2*NUM_PORTS-1:0]  w_valid_x2;
    logic [2*NUM_PORTS-1:0]  w_valid_rot;
    logic [ID_WIDTH:0]       w_start;
    logic [ID_WIDTH:0]       w_sum;

    assign grant_id     = r_grant_id;
    assign busy         = (r_state != ST_IDLE);
    assign block_done   = r_block_done;
    assign blocks_total = r_blocks_total;
    assign w_xfer       = out_valid && out_ready;

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_grant_id == ID_WIDTH'(i)) begin
                w_sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = in_valid[i];
            end
        end
    end

    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        if (r_state != ST_IDLE) begin
            out_valid = w_sel_valid;
            out_data  = w_sel_data;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (r_grant_id == ID_WIDTH'(i)) begin
                    in_ready[i] = out_ready;
                end
            end
        end
    end

    // Rotate the doubled valid vector so bit 0 is the port after the last grant;
    // the first set bit then gives the round-robin winner as an offset.
    assign w_start     = {1'b0, r_grant_id} + (ID_WIDTH+1)'(1);
    assign w_valid_x2  = {in_valid, in_valid};
    assign w_valid_rot = w_valid_x2 >> w_start;

    always_comb begin
        w_any = 1'b0;
        w_sum = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!w_any && w_valid_rot[i]) begin
                w_any = 1'b1;
                w_sum = w_start + (ID_WIDTH+1)'(i);
            end
        end
        if (w_sum >= (ID_WIDTH+1)'(NUM_PORTS)) begin
            w_pick = ID_WIDTH'(w_sum - (ID_WIDTH+1)'(NUM_PORTS));
        end else begin
            w_pick = ID_WIDTH'(w_sum);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant_id;
        w_remaining_nxt = r_remaining;
        w_done          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    w_remaining_nxt = out_data[15:0];
                    if (out_data[15:0] == 16'd0) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (w_xfer) begin
                    w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Flush overrides everything, including a coincident block completion.
        if (flush) begin
            w_state_nxt     = ST_IDLE;
            w_grant_nxt     = r_grant_id;
            w_remaining_nxt = '0;
            w_done          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id     <= ID_WIDTH'(NUM_PORTS - 1);
            r_remaining    <= '0;
            r_block_done   <= 1'b0;
            r_blocks_total <= '0;
        end else begin
            r_grant_id     <= w_grant_nxt;
            r_remaining    <= w_remaining_nxt;
            r_block_done   <= w_done;
            r_blocks_total <= r_blocks_total + {15'd0, w_done};
        end
    end

endmodule
